// File: rtl/huffman_decoder.sv
// Serial prefix-code decoder: a six-entry codeword/mask table is loaded by strobe,
// then incoming bits (MSB first) are shifted in until one table entry matches.
module huffman_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       frame_end,
  output logic       in_ready,
  output logic       sym_valid,
  output logic [7:0] sym_out,
  output logic       err,
  output logic [7:0] sym_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    IDLE    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [5:0][7:0] hc_q, hc_d;
  logic [5:0][7:0] m_q, m_d;
  logic [6:0]      acc_q, acc_d;
  logic [2:0]      len_q, len_d;
  logic [7:0]      sym_out_d, sym_cnt_d;
  logic            sym_valid_d, err_d;

  logic [7:0]      acc_n;
  logic [3:0]      len_n;
  logic [8:0]      mask_wide;
  logic [7:0]      full_mask;
  logic            hit;
  logic [2:0]      hit_idx;

  assign in_ready = (state_q != EMPTY);

  // Candidate codeword after accepting bit_in, and the mask a symbol of that length must carry.
  always_comb begin
    acc_n     = {acc_q, bit_in};
    len_n     = {1'b0, len_q} + 4'd1;
    mask_wide = (9'd1 << len_n) - 9'd1;
    full_mask = mask_wide[7:0];
  end

  // Scan from the highest index down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (m_q[i] == full_mask && (acc_n & m_q[i]) == hc_q[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i + 1);
      end
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    m_d         = m_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_out_d   = sym_out;
    sym_cnt_d   = sym_cnt;
    sym_valid_d = 1'b0;
    err_d       = 1'b0;

    if (code_valid) begin
      hc_d      = {HC6, HC5, HC4, HC3, HC2, HC1};
      m_d       = {M6, M5, M4, M3, M2, M1};
      acc_d     = '0;
      len_d     = '0;
      sym_cnt_d = '0;
      state_d   = IDLE;
    end else if (state_q != EMPTY) begin
      if (bit_valid) begin
        if (hit) begin
          sym_out_d   = {5'd0, hit_idx};
          sym_valid_d = 1'b1;
          sym_cnt_d   = sym_cnt + 8'd1;
          acc_d       = '0;
          len_d       = '0;
          state_d     = IDLE;
        end else if (len_n == 4'd8) begin
          err_d   = 1'b1;
          acc_d   = '0;
          len_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = acc_n[6:0];
          len_d   = len_n[2:0];
          state_d = COLLECT;
        end
      end
      // End of stream is judged on the length left after this cycle's bit, if any.
      if (frame_end && len_d != 3'd0) begin
        err_d   = 1'b1;
        acc_d   = '0;
        len_d   = '0;
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      // NOTE: the code table is explicitly cleared on reset; it is a handful of flops, not a RAM.
      hc_q      <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      len_q     <= '0;
      sym_out   <= '0;
      sym_cnt   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      sym_out   <= sym_out_d;
      sym_cnt   <= sym_cnt_d;
      sym_valid <= sym_valid_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: a bit-string reference model checked every
// cycle, plus literal expectations taken from the directed scenarios.
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset, code_valid, bit_valid, bit_in, frame_end;
  logic [7:0] hc_in [6];
  logic [7:0] m_in  [6];
  logic       in_ready, sym_valid, err;
  logic [7:0] sym_out, sym_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc_in[0]), .HC2(hc_in[1]), .HC3(hc_in[2]),
    .HC4(hc_in[3]), .HC5(hc_in[4]), .HC6(hc_in[5]),
    .M1(m_in[0]), .M2(m_in[1]), .M3(m_in[2]),
    .M4(m_in[3]), .M5(m_in[4]), .M6(m_in[5]),
    .bit_valid(bit_valid), .bit_in(bit_in), .frame_end(frame_end),
    .in_ready(in_ready), .sym_valid(sym_valid), .sym_out(sym_out),
    .err(err), .sym_cnt(sym_cnt)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the received bits as a value plus a count and asks,
  // for each table entry, whether its mask is a run of exactly that many ones.
  logic [7:0] t_hc [6];
  logic [7:0] t_m  [6];
  bit         loaded = 1'b0;
  int         nbits  = 0;
  logic [7:0] val    = '0;
  logic [7:0] exp_sym = '0, exp_cnt = '0;
  logic       exp_valid = 1'b0, exp_err = 1'b0, exp_ready = 1'b0;

  function automatic int ones(input logic [7:0] m);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(m[k]);
    return n;
  endfunction

  always @(posedge clk) begin
    bit found;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (reset) begin
      loaded = 1'b0; nbits = 0; val = '0; exp_sym = '0; exp_cnt = '0;
      for (int k = 0; k < 6; k++) begin t_hc[k] = '0; t_m[k] = '0; end
    end else if (code_valid) begin
      loaded = 1'b1; nbits = 0; val = '0; exp_cnt = '0;
      for (int k = 0; k < 6; k++) begin t_hc[k] = hc_in[k]; t_m[k] = m_in[k]; end
    end else if (loaded) begin
      if (bit_valid) begin
        val   = {val[6:0], bit_in};
        nbits = nbits + 1;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
          if (!found && ones(t_m[k]) == nbits && ((t_m[k] & (t_m[k] + 8'd1)) == 8'd0)
              && ((val & t_m[k]) == t_hc[k])) begin
            found     = 1'b1;
            exp_valid = 1'b1;
            exp_sym   = 8'(k + 1);
          end
        end
        if (found) begin
          exp_cnt = exp_cnt + 8'd1; nbits = 0; val = '0;
        end else if (nbits == 8) begin
          exp_err = 1'b1; nbits = 0; val = '0;
        end
      end
      if (frame_end && nbits != 0) begin
        exp_err = 1'b1; nbits = 0; val = '0;
      end
    end
    exp_ready = loaded;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_in_ready",  {7'd0, in_ready},  {7'd0, exp_ready});
      check("cyc_sym_valid", {7'd0, sym_valid}, {7'd0, exp_valid});
      check("cyc_err",       {7'd0, err},       {7'd0, exp_err});
      check("cyc_sym_out",   sym_out,           exp_sym);
      check("cyc_sym_cnt",   sym_cnt,           exp_cnt);
    end
  end

  // Inputs change 1 ns after the rising edge; each call covers one clock cycle.
  task automatic drive(input logic cv, input logic bv, input logic b, input logic fe, input logic rst);
    code_valid = cv; bit_valid = bv; bit_in = b; frame_end = fe; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    drive(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_table(input logic [7:0] m6);
    hc_in[0] = 8'h00; m_in[0] = 8'h01;
    hc_in[1] = 8'h02; m_in[1] = 8'h03;
    hc_in[2] = 8'h06; m_in[2] = 8'h07;
    hc_in[3] = 8'h0E; m_in[3] = 8'h0F;
    hc_in[4] = 8'h1E; m_in[4] = 8'h1F;
    hc_in[5] = 8'h1F; m_in[5] = m6;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin hc_in[k] = '0; m_in[k] = '0; end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_in_ready", {7'd0, in_ready}, 8'd0);
    check("rst_sym_cnt", sym_cnt, 8'd0);

    // Bits and frame_end before any table load are ignored.
    send(1'b1); send(1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("empty_in_ready", {7'd0, in_ready}, 8'd0);
    check("empty_err", {7'd0, err}, 8'd0);

    // V-1
    load_table(8'h1F);
    check("load_in_ready", {7'd0, in_ready}, 8'd1);
    send(1'b0);
    check("v1_valid1", {7'd0, sym_valid}, 8'd1);
    check("v1_sym1", sym_out, 8'd1);
    send(1'b1);
    check("v1_mid_valid", {7'd0, sym_valid}, 8'd0);
    send(1'b0);
    check("v1_sym2", sym_out, 8'd2);
    send(1'b1); send(1'b1); send(1'b0);
    check("v1_valid3", {7'd0, sym_valid}, 8'd1);
    check("v1_sym3", sym_out, 8'd3);
    check("v1_cnt", sym_cnt, 8'd3);
    idle();
    check("v1_hold_valid", {7'd0, sym_valid}, 8'd0);
    check("v1_hold_sym", sym_out, 8'd3);

    // V-2
    load_table(8'h1F);
    repeat (5) send(1'b1);
    check("v2_sym6", sym_out, 8'd6);
    repeat (4) send(1'b1);
    send(1'b0);
    check("v2_sym5", sym_out, 8'd5);
    check("v2_cnt", sym_cnt, 8'd2);

    // V-3: truncated codeword at end of frame
    send(1'b1); send(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("v3_err", {7'd0, err}, 8'd1);
    check("v3_no_valid", {7'd0, sym_valid}, 8'd0);
    send(1'b0);
    check("v3_sym1", sym_out, 8'd1);
    check("v3_valid", {7'd0, sym_valid}, 8'd1);

    // frame_end in IDLE, with a completing bit, and with a non-completing bit
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fe_idle_err", {7'd0, err}, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fe_complete_err", {7'd0, err}, 8'd0);
    check("fe_complete_valid", {7'd0, sym_valid}, 8'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("fe_partial_err", {7'd0, err}, 8'd1);

    // A table reload discards a partial codeword silently.
    send(1'b1); send(1'b1);
    load_table(8'h1F);
    check("reload_err", {7'd0, err}, 8'd0);
    send(1'b0);
    check("reload_sym1", sym_out, 8'd1);

    // V-4: symbol 6 disabled, eight ones overflow
    load_table(8'h00);
    repeat (7) send(1'b1);
    check("v4_pre_err", {7'd0, err}, 8'd0);
    send(1'b1);
    check("v4_err", {7'd0, err}, 8'd1);
    check("v4_no_valid", {7'd0, sym_valid}, 8'd0);
    idle();

    // V-5: reset during COLLECT
    load_table(8'h1F);
    send(1'b0);
    send(1'b1); send(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("v5_in_ready", {7'd0, in_ready}, 8'd0);
    check("v5_sym_out", sym_out, 8'd0);
    check("v5_sym_cnt", sym_cnt, 8'd0);
    check("v5_err", {7'd0, err}, 8'd0);
    idle();
    send(1'b0);
    check("v5_empty_valid", {7'd0, sym_valid}, 8'd0);

    // V-6: counter wrap, then code_valid together with bit_valid
    load_table(8'h1F);
    repeat (255) send(1'b0);
    check("v6_cnt255", sym_cnt, 8'd255);
    send(1'b0);
    check("v6_wrap", sym_cnt, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("v6_cv_valid", {7'd0, sym_valid}, 8'd0);
    check("v6_cv_cnt", sym_cnt, 8'd0);
    send(1'b0);
    check("v6_after_cnt", sym_cnt, 8'd1);
    idle(); idle();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port code_valid, input, 1 bit: single-cycle table-load strobe.
REQ-005 Ports HC1..HC6, input, 8 bits each: symbol codewords, right-aligned.
REQ-006 Ports M1..M6, input, 8 bits each: codeword masks, contiguous ones from bit 0; mask 8'h00 disables the symbol.
REQ-007 Port bit_valid, input, 1 bit: bit_in is valid this cycle.
REQ-008 Port bit_in, input, 1 bit: serial code bit; the first bit received is the codeword MSB.
REQ-009 Port frame_end, input, 1 bit: end-of-stream strobe.
REQ-010 Port in_ready, output, 1 bit: table loaded and bits accepted.
REQ-011 Port sym_valid, output, 1 bit: single-cycle decoded-symbol strobe.
REQ-012 Port sym_out, output, 8 bits: decoded symbol value, 8'd1..8'd6.
REQ-013 Port err, output, 1 bit: single-cycle decode-error strobe.
REQ-014 Port sym_cnt, output, 8 bits: symbols decoded since the last table load; wraps at 255 to 0.

Function
REQ-015 States SHALL be EMPTY (no table), IDLE (table loaded, accumulator empty) and COLLECT (accumulator length 1..7).
REQ-016 On a code_valid cycle, HC1..HC6 and M1..M6 SHALL be registered into the internal table in any state, the accumulator SHALL be cleared, sym_cnt SHALL be cleared, and the next state SHALL be IDLE.
REQ-017 A code_valid cycle SHALL discard a partial codeword without asserting err, and bit_valid in that same cycle SHALL be ignored.
REQ-018 in_ready SHALL be 1 in IDLE and COLLECT and 0 in EMPTY; bit_valid and frame_end in EMPTY SHALL be ignored.
REQ-019 An accepted bit SHALL form acc_n = {acc[6:0], bit_in} with length len_n = len + 1.
REQ-020 Symbol i SHALL match when M_i == (2^len_n) - 1 and (acc_n & M_i) == HC_i; if several symbols match, the lowest index SHALL win.
REQ-021 On a match, sym_out SHALL be i and sym_valid SHALL be 1 in the cycle after the accepting edge (one-cycle latency).
REQ-022 On a match, the accumulator SHALL be cleared, sym_cnt SHALL increment, and the next state SHALL be IDLE.
REQ-023 On no match with len_n < 8, the next state SHALL be COLLECT.
REQ-024 On no match with len_n == 8, err SHALL be 1 the next cycle, the accumulator SHALL be cleared, and the next state SHALL be IDLE.
REQ-025 frame_end in COLLECT without a completing bit in the same cycle SHALL produce err the next cycle and return to IDLE.
REQ-026 frame_end in IDLE SHALL have no effect.
REQ-027 frame_end in the same cycle as an accepted bit SHALL evaluate the bit first; frame_end SHALL raise err only if len_n != 0 after that evaluation.
REQ-028 Back-to-back bits SHALL be accepted every cycle with no bubbles; consecutive symbols SHALL produce consecutive sym_valid pulses.
REQ-029 sym_out SHALL hold its last value when sym_valid is 0.

Reset
REQ-030 reset SHALL take priority over code_valid and bit_valid.
REQ-031 On reset: state EMPTY; table, accumulator, sym_out, and sym_cnt 0; sym_valid, err, and in_ready 0.
REQ-032 Reset during COLLECT SHALL discard the partial codeword without asserting err.

Verification
Table used in scenarios V-1 to V-4: HC1=0 M1=01, HC2=02 M2=03, HC3=06 M3=07, HC4=0E M4=0F, HC5=1E M5=1F, HC6=1F M6=1F.
V-1 Load the table, then send bits 0,1,0,1,1,0 back-to-back -> sym_out 1,2,3; each sym_valid one cycle after the completing bit; sym_cnt=3.
V-2 Send bits 1,1,1,1,1 then 1,1,1,1,0 -> sym_out 6 then 5; sym_cnt=2.
V-3 Send bits 1,1 then frame_end -> err pulse one cycle later, no sym_valid, state IDLE; then send 0 -> sym_out 1.
V-4 Set M6=00 and send 1,1,1,1,1,1,1,1 -> no sym_valid; err one cycle after the 8th bit.
V-5 Send bit_valid=1 before any code_valid -> in_ready=0, no outputs; then assert reset during COLLECT (after bits 1,1) -> all outputs 0, state EMPTY.
V-6 With sym_cnt=255, decode one more symbol -> sym_cnt=0; then assert code_valid together with bit_valid -> the bit is ignored and sym_cnt=0.
